// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Definitions shared by the instruction fetch stage and the controller:
//   - fetch_state_e : fetch FSM states (ISSUE, WAIT, VALID)
//   - NOOP          : instruction register reset value
//   - PC_WIDTH_DEF / INSTR_WIDTH_DEF : default PC and instruction widths
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int unsigned PC_WIDTH_DEF    = 7;
   localparam int unsigned INSTR_WIDTH_DEF = 16;

   localparam logic [15:0] NOOP = 16'h0000;

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      WAIT  = 2'd1,
      VALID = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Instruction ROM read bus between the fetch stage and the ROM.
//   addr : ROM word address (driven by fetch, equals PC)
//   rd   : one-cycle read strobe (driven by fetch)
//   data : ROM read data, valid ROM_LATENCY cycles after the rd edge
// Modports: master = fetch stage, slave = ROM.
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
   parameter int unsigned PC_WIDTH    = 7,
   parameter int unsigned INSTR_WIDTH = 16
) ();

   logic [PC_WIDTH-1:0]    addr;
   logic                   rd;
   logic [INSTR_WIDTH-1:0] data;

   modport master (
      output addr,
      output rd,
      input  data
   );

   modport slave (
      input  addr,
      input  rd,
      output data
   );

endinterface

// File: rtl/pc_counter.sv
// -----------------------------------------------------------------------------
// pc_counter
// Program counter register. Priority: clear > load > increment. The increment
// wraps silently modulo 2**PC_WIDTH.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (PC -> 0)
//   i_clr       : clear PC to 0
//   i_ld        : load PC from i_ld_val
//   i_ld_val    : load value
//   i_up        : increment PC
//   o_pc        : current PC
// -----------------------------------------------------------------------------
module pc_counter
   import fetch_pkg::*;
#(
   parameter int unsigned PC_WIDTH = PC_WIDTH_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_clr,
   input  logic                i_ld,
   input  logic [PC_WIDTH-1:0] i_ld_val,
   input  logic                i_up,
   output logic [PC_WIDTH-1:0] o_pc
);

   logic [PC_WIDTH-1:0] r_pc;
   logic [PC_WIDTH-1:0] w_pc_d;

   always_comb begin
      w_pc_d = r_pc;
      if (i_clr) begin
         w_pc_d = '0;
      end else if (i_ld) begin
         w_pc_d = i_ld_val;
      end else if (i_up) begin
         w_pc_d = r_pc + PC_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= '0;
      end else begin
         r_pc <= w_pc_d;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage: owns the PC, reads the instruction ROM into a one-word prefetch
// buffer and loads the instruction register (IR) on controller request.
// Optional feature macro: INSTR_FETCH_JUMP_EN adds i_pc_ld / i_pc_ld_val.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_pc_clr     : clear PC to 0, abandon in-flight read, drop pending work
//   i_pc_up      : increment PC (deferred while an IR load is pending)
//   i_ir_ld      : load IR with ROM[PC]
//   i_pc_ld      : (JUMP_EN) load PC from i_pc_ld_val
//   i_pc_ld_val  : (JUMP_EN) jump target
//   rom          : ROM read bus (master side)
//   o_fetch_rdy  : prefetch buffer holds ROM[PC]
//   o_ld_pend    : IR load accepted, waiting for ROM data
//   o_pc         : program counter
//   o_ir         : instruction register
// -----------------------------------------------------------------------------
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = PC_WIDTH_DEF,
   parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEF,
   // legal range 1..4
   parameter int unsigned ROM_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_pc_clr,
   input  logic                   i_pc_up,
   input  logic                   i_ir_ld,
`ifdef INSTR_FETCH_JUMP_EN
   input  logic                   i_pc_ld,
   input  logic [PC_WIDTH-1:0]    i_pc_ld_val,
`endif
   instr_fetch_if.master          rom,
   output logic                   o_fetch_rdy,
   output logic                   o_ld_pend,
   output logic [PC_WIDTH-1:0]    o_pc,
   output logic [INSTR_WIDTH-1:0] o_ir
);

   localparam int unsigned CNT_W = 3;

   fetch_state_e           r_state, w_state_d;
   logic [CNT_W-1:0]       r_cnt, w_cnt_d;
   logic [INSTR_WIDTH-1:0] r_buf, w_buf_d;
   logic [INSTR_WIDTH-1:0] r_ir, w_ir_d;
   logic                   r_ld_pend, w_ld_pend_d;
   logic                   r_up_pend, w_up_pend_d;

   logic                   w_jmp;
   logic [PC_WIDTH-1:0]    w_jmp_val;
   logic [PC_WIDTH-1:0]    w_pc;
   logic                   w_valid;
   logic                   w_blocked;
   logic                   w_up;
   logic                   w_fill;

`ifdef INSTR_FETCH_JUMP_EN
   assign w_jmp     = i_pc_ld & ~i_pc_clr;
   assign w_jmp_val = i_pc_ld_val;
`else
   assign w_jmp     = 1'b0;
   assign w_jmp_val = '0;
`endif

   assign w_valid   = (r_state == VALID);
   // An increment must wait while an IR load (old or new) still needs ROM[PC].
   assign w_blocked = r_ld_pend | (i_ir_ld & ~w_valid);
   assign w_up      = (i_pc_up | r_up_pend) & ~w_blocked & ~i_pc_clr & ~w_jmp;
   // Data-sampling edge of the current read, unless the read is being abandoned.
   assign w_fill    = (r_state == WAIT) && (r_cnt == CNT_W'(1)) &&
                      !i_pc_clr && !w_jmp && !w_up;

   pc_counter #(
      .PC_WIDTH (PC_WIDTH)
   ) u_pc_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clr    (i_pc_clr),
      .i_ld     (w_jmp),
      .i_ld_val (w_jmp_val),
      .i_up     (w_up),
      .o_pc     (w_pc)
   );

   always_comb begin
      w_state_d   = r_state;
      w_cnt_d     = r_cnt;
      w_buf_d     = r_buf;
      w_ir_d      = r_ir;
      w_ld_pend_d = r_ld_pend;
      w_up_pend_d = r_up_pend;

      unique case (r_state)
         ISSUE: begin
            w_state_d = WAIT;
            w_cnt_d   = CNT_W'(ROM_LATENCY);
         end
         WAIT: begin
            w_cnt_d = r_cnt - CNT_W'(1);
            if (w_fill) begin
               w_state_d = VALID;
               w_buf_d   = rom.data;
            end
         end
         VALID: begin
         end
         default: w_state_d = ISSUE;
      endcase

      // Any PC change restarts the read at the new address.
      if (i_pc_clr || w_jmp || w_up) begin
         w_state_d = ISSUE;
      end

      if (!i_pc_clr) begin
         if (w_valid && i_ir_ld) begin
            w_ir_d = r_buf;
         end else if (w_fill && (r_ld_pend || i_ir_ld)) begin
            w_ir_d = rom.data;
         end
      end

      if (i_pc_clr || w_fill) begin
         w_ld_pend_d = 1'b0;
      end else if (i_ir_ld && !w_valid) begin
         w_ld_pend_d = 1'b1;
      end

      if (i_pc_clr || w_jmp || w_up) begin
         w_up_pend_d = 1'b0;
      end else if (i_pc_up && w_blocked) begin
         w_up_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ISSUE;
         r_cnt     <= '0;
         r_buf     <= '0;
         r_ir      <= INSTR_WIDTH'(NOOP);
         r_ld_pend <= 1'b0;
         r_up_pend <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_cnt     <= w_cnt_d;
         r_buf     <= w_buf_d;
         r_ir      <= w_ir_d;
         r_ld_pend <= w_ld_pend_d;
         r_up_pend <= w_up_pend_d;
      end
   end

   // Gated by reset so the strobe is low while reset holds the FSM in ISSUE.
   assign rom.rd      = (r_state == ISSUE) & rst_n;
   assign rom.addr    = w_pc;
   assign o_fetch_rdy = w_valid;
   assign o_ld_pend   = r_ld_pend;
   assign o_pc        = w_pc;
   assign o_ir        = r_ir;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   logic [15:0] rom [128];
   logic [15:0] exp_q [$];
   logic [15:0] exp;

   // DUT A: ROM_LATENCY = 1
   logic a_pc_clr = 1'b0, a_pc_up = 1'b0, a_ir_ld = 1'b0;
   logic a_rdy, a_pend;
   logic [6:0] a_pc;
   logic [15:0] a_ir;
   logic [15:0] a_pipe;
   instr_fetch_if #(.PC_WIDTH(7), .INSTR_WIDTH(16)) a_bus ();

   // DUT B: ROM_LATENCY = 3
   logic b_pc_clr = 1'b0, b_pc_up = 1'b0, b_ir_ld = 1'b0;
   logic b_rdy, b_pend;
   logic [6:0] b_pc;
   logic [15:0] b_ir;
   logic [15:0] b_pipe [3];
   instr_fetch_if #(.PC_WIDTH(7), .INSTR_WIDTH(16)) b_bus ();

   instr_fetch #(.PC_WIDTH(7), .INSTR_WIDTH(16), .ROM_LATENCY(1)) dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_pc_clr    (a_pc_clr),
      .i_pc_up     (a_pc_up),
      .i_ir_ld     (a_ir_ld),
`ifdef INSTR_FETCH_JUMP_EN
      .i_pc_ld     (1'b0),
      .i_pc_ld_val (7'd0),
`endif
      .rom         (a_bus),
      .o_fetch_rdy (a_rdy),
      .o_ld_pend   (a_pend),
      .o_pc        (a_pc),
      .o_ir        (a_ir)
   );

   instr_fetch #(.PC_WIDTH(7), .INSTR_WIDTH(16), .ROM_LATENCY(3)) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_pc_clr    (b_pc_clr),
      .i_pc_up     (b_pc_up),
      .i_ir_ld     (b_ir_ld),
`ifdef INSTR_FETCH_JUMP_EN
      .i_pc_ld     (1'b0),
      .i_pc_ld_val (7'd0),
`endif
      .rom         (b_bus),
      .o_fetch_rdy (b_rdy),
      .o_ld_pend   (b_pend),
      .o_pc        (b_pc),
      .o_ir        (b_ir)
   );

   // ROM models: data is only meaningful exactly LATENCY cycles after a read edge.
   always @(posedge clk) a_pipe <= a_bus.rd ? rom[a_bus.addr] : 16'hDEAD;
   assign a_bus.data = a_pipe;

   always @(posedge clk) begin
      b_pipe[0] <= b_bus.rd ? rom[b_bus.addr] : 16'hDEAD;
      b_pipe[1] <= b_pipe[0];
      b_pipe[2] <= b_pipe[1];
   end
   assign b_bus.data = b_pipe[2];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      {a_pc_clr, a_pc_up, a_ir_ld, b_pc_clr, b_pc_up, b_ir_ld} = '0;
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_rdy_a();
      for (int i = 0; i < 20 && a_rdy !== 1'b1; i++) tick();
      n_checks++;
      if (a_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL a_rdy_timeout: got %b expected 1", a_rdy);
      end
   endtask

   task automatic wait_rdy_b();
      for (int i = 0; i < 20 && b_rdy !== 1'b1; i++) tick();
      n_checks++;
      if (b_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL b_rdy_timeout: got %b expected 1", b_rdy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_checks += 5;
      if (a_pc !== 7'd0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", a_pc); end
      if (a_ir !== 16'h0000) begin n_fail++; $display("FAIL reset_ir: got %h expected 0000", a_ir); end
      if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", a_rdy); end
      if (a_pend !== 1'b0) begin n_fail++; $display("FAIL reset_pend: got %b expected 0", a_pend); end
      if (a_bus.rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b expected 0", a_bus.rd); end
      rst_n = 1'b1;
      #1;
      n_checks += 2;
      if (a_bus.rd !== 1'b1) begin n_fail++; $display("FAIL first_rd: got %b expected 1", a_bus.rd); end
      if (a_bus.addr !== 7'd0) begin n_fail++; $display("FAIL first_addr: got %h expected 0", a_bus.addr); end
      tick();
      n_checks += 2;
      if (a_bus.rd !== 1'b0) begin n_fail++; $display("FAIL rd_one_cycle: got %b expected 0", a_bus.rd); end
      if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL rdy_early: got %b expected 0", a_rdy); end
      tick();
      n_checks++;
      if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL rdy_lat1: got %b expected 1", a_rdy); end
      a_ir_ld = 1'b1;
      exp_q.push_back(rom[0]);
      tick();
      a_ir_ld = 1'b0;
      n_checks += 2;
      if (a_pend !== 1'b0) begin n_fail++; $display("FAIL pend_zero_wait: got %b expected 0", a_pend); end
      if (exp_q.size() == 0) exp = 'x; else exp = exp_q.pop_front();
      if (a_ir !== exp) begin n_fail++; $display("FAIL ir_reset_load: got %h expected %h", a_ir, exp); end
   endtask

   task automatic test_ld_pend();
      do_reset();
      b_ir_ld = 1'b1;
      exp_q.push_back(rom[0]);
      for (int c = 1; c <= 3; c++) begin
         tick();
         // second request mid-wait must be absorbed
         b_ir_ld = (c == 2);
         n_checks += 2;
         if (b_pend !== 1'b1) begin n_fail++; $display("FAIL ld_pend_c%0d: got %b expected 1", c, b_pend); end
         if (b_ir !== 16'h0000) begin n_fail++; $display("FAIL ir_early_c%0d: got %h expected 0000", c, b_ir); end
      end
      tick();
      b_ir_ld = 1'b0;
      n_checks += 3;
      if (b_pend !== 1'b0) begin n_fail++; $display("FAIL ld_pend_clear: got %b expected 0", b_pend); end
      if (b_rdy !== 1'b1) begin n_fail++; $display("FAIL rdy_lat3: got %b expected 1", b_rdy); end
      if (exp_q.size() == 0) exp = 'x; else exp = exp_q.pop_front();
      if (b_ir !== exp) begin n_fail++; $display("FAIL ir_fill_load: got %h expected %h", b_ir, exp); end
      tick();
      n_checks++;
      if (b_pend !== 1'b0) begin n_fail++; $display("FAIL ld_absorbed: got %b expected 0", b_pend); end
   endtask

   task automatic test_pending_up();
      do_reset();
      a_ir_ld = 1'b1;
      a_pc_up = 1'b1;
      exp_q.push_back(rom[0]);
      tick();
      a_ir_ld = 1'b0;
      n_checks += 2;
      if (a_pend !== 1'b1) begin n_fail++; $display("FAIL both_pend: got %b expected 1", a_pend); end
      if (a_pc !== 7'd0) begin n_fail++; $display("FAIL up_deferred: got %h expected 00", a_pc); end
      tick();
      a_pc_up = 1'b0;
      n_checks += 2;
      if (a_pc !== 7'd0) begin n_fail++; $display("FAIL up_after_fill: got %h expected 00", a_pc); end
      if (exp_q.size() == 0) exp = 'x; else exp = exp_q.pop_front();
      if (a_ir !== exp) begin n_fail++; $display("FAIL ir_pend_load: got %h expected %h", a_ir, exp); end
      tick();
      n_checks += 2;
      if (a_pc !== 7'd1) begin n_fail++; $display("FAIL up_applied: got %h expected 01", a_pc); end
      if (a_bus.rd !== 1'b1) begin n_fail++; $display("FAIL up_reissue: got %b expected 1", a_bus.rd); end
      tick();
      n_checks++;
      if (a_pc !== 7'd1) begin n_fail++; $display("FAIL up_absorbed: got %h expected 01", a_pc); end
   endtask

   task automatic test_ir_up_valid();
      a_pc_up = 1'b1;
      repeat (4) tick();
      a_pc_up = 1'b0;
      wait_rdy_a();
      a_ir_ld = 1'b1;
      a_pc_up = 1'b1;
      exp_q.push_back(rom[5]);
      tick();
      a_ir_ld = 1'b0;
      a_pc_up = 1'b0;
      n_checks += 5;
      if (exp_q.size() == 0) exp = 'x; else exp = exp_q.pop_front();
      if (a_ir !== exp) begin n_fail++; $display("FAIL ir_up_ir: got %h expected %h", a_ir, exp); end
      if (a_pc !== 7'd6) begin n_fail++; $display("FAIL ir_up_pc: got %h expected 06", a_pc); end
      if (a_bus.rd !== 1'b1) begin n_fail++; $display("FAIL ir_up_rd: got %b expected 1", a_bus.rd); end
      if (a_bus.addr !== 7'd6) begin n_fail++; $display("FAIL ir_up_addr: got %h expected 06", a_bus.addr); end
      if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL ir_up_rdy: got %b expected 0", a_rdy); end
   endtask

   task automatic test_wrap();
      a_pc_up = 1'b1;
      repeat (121) tick();
      a_pc_up = 1'b0;
      n_checks++;
      if (a_pc !== 7'd127) begin n_fail++; $display("FAIL pc_127: got %h expected 7f", a_pc); end
      wait_rdy_a();
      a_ir_ld = 1'b1;
      exp_q.push_back(rom[127]);
      tick();
      a_ir_ld = 1'b0;
      n_checks++;
      if (exp_q.size() == 0) exp = 'x; else exp = exp_q.pop_front();
      if (a_ir !== exp) begin n_fail++; $display("FAIL ir_127: got %h expected %h", a_ir, exp); end
      a_pc_up = 1'b1;
      tick();
      a_pc_up = 1'b0;
      n_checks += 4;
      if (a_pc !== 7'd0) begin n_fail++; $display("FAIL wrap_pc: got %h expected 00", a_pc); end
      if (a_bus.rd !== 1'b1) begin n_fail++; $display("FAIL wrap_rd: got %b expected 1", a_bus.rd); end
      if (a_bus.addr !== 7'd0) begin n_fail++; $display("FAIL wrap_addr: got %h expected 00", a_bus.addr); end
      if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL wrap_rdy0: got %b expected 0", a_rdy); end
      tick();
      n_checks++;
      if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL wrap_rdy1: got %b expected 0", a_rdy); end
      tick();
      n_checks++;
      if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL wrap_rdy2: got %b expected 1", a_rdy); end
      a_ir_ld = 1'b1;
      exp_q.push_back(rom[0]);
      tick();
      a_ir_ld = 1'b0;
      n_checks++;
      if (exp_q.size() == 0) exp = 'x; else exp = exp_q.pop_front();
      if (a_ir !== exp) begin n_fail++; $display("FAIL wrap_ir: got %h expected %h", a_ir, exp); end
   endtask

   task automatic test_clr_wait();
      do_reset();
      wait_rdy_b();
      b_pc_up = 1'b1;
      repeat (2) tick();
      b_pc_up = 1'b0;
      wait_rdy_b();
      b_ir_ld = 1'b1;
      exp_q.push_back(rom[2]);
      tick();
      b_ir_ld = 1'b0;
      n_checks++;
      if (exp_q.size() == 0) exp = 'x; else exp = exp_q.pop_front();
      if (b_ir !== exp) begin n_fail++; $display("FAIL clr_pre_ir: got %h expected %h", b_ir, exp); end
      b_pc_up = 1'b1;
      repeat (7) tick();
      b_pc_up = 1'b0;
      b_ir_ld = 1'b1;
      tick();
      b_ir_ld = 1'b0;
      n_checks += 2;
      if (b_pc !== 7'd9) begin n_fail++; $display("FAIL clr_pc9: got %h expected 09", b_pc); end
      if (b_pend !== 1'b1) begin n_fail++; $display("FAIL clr_pend_set: got %b expected 1", b_pend); end
      tick();
      b_pc_clr = 1'b1;
      tick();
      b_pc_clr = 1'b0;
      n_checks += 4;
      if (b_pc !== 7'd0) begin n_fail++; $display("FAIL clr_pc: got %h expected 00", b_pc); end
      if (b_pend !== 1'b0) begin n_fail++; $display("FAIL clr_pend: got %b expected 0", b_pend); end
      if (b_bus.rd !== 1'b1) begin n_fail++; $display("FAIL clr_rd: got %b expected 1", b_bus.rd); end
      if (b_ir !== rom[2]) begin n_fail++; $display("FAIL clr_ir_kept: got %h expected %h", b_ir, rom[2]); end
      for (int c = 0; c < 4; c++) begin
         tick();
         n_checks++;
         if (b_ir !== rom[2]) begin n_fail++; $display("FAIL clr_stale_c%0d: got %h expected %h", c, b_ir, rom[2]); end
      end
      n_checks++;
      if (b_rdy !== 1'b1) begin n_fail++; $display("FAIL clr_refill_rdy: got %b expected 1", b_rdy); end
      b_ir_ld = 1'b1;
      exp_q.push_back(rom[0]);
      tick();
      b_ir_ld = 1'b0;
      n_checks++;
      if (exp_q.size() == 0) exp = 'x; else exp = exp_q.pop_front();
      if (b_ir !== exp) begin n_fail++; $display("FAIL clr_buf_ir: got %h expected %h", b_ir, exp); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      wait_rdy_b();
      b_ir_ld = 1'b1;
      exp_q.push_back(rom[0]);
      tick();
      b_ir_ld = 1'b0;
      n_checks++;
      if (exp_q.size() == 0) exp = 'x; else exp = exp_q.pop_front();
      if (b_ir !== exp) begin n_fail++; $display("FAIL mid_pre_ir: got %h expected %h", b_ir, exp); end
      b_pc_up = 1'b1;
      tick();
      b_pc_up = 1'b0;
      b_ir_ld = 1'b1;
      tick();
      b_ir_ld = 1'b0;
      n_checks++;
      if (b_pend !== 1'b1) begin n_fail++; $display("FAIL mid_pend_set: got %b expected 1", b_pend); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks += 5;
      if (b_ir !== 16'h0000) begin n_fail++; $display("FAIL mid_ir: got %h expected 0000", b_ir); end
      if (b_pc !== 7'd0) begin n_fail++; $display("FAIL mid_pc: got %h expected 00", b_pc); end
      if (b_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_rdy: got %b expected 0", b_rdy); end
      if (b_pend !== 1'b0) begin n_fail++; $display("FAIL mid_pend: got %b expected 0", b_pend); end
      if (b_bus.rd !== 1'b0) begin n_fail++; $display("FAIL mid_rd: got %b expected 0", b_bus.rd); end
      tick();
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (b_bus.rd !== 1'b1) begin n_fail++; $display("FAIL mid_release_rd: got %b expected 1", b_bus.rd); end
      wait_rdy_b();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 128; i++) rom[i] = 16'h4000 + 16'(i * 3);
      rom[0]   = 16'h1505;
      rom[2]   = 16'h2222;
      rom[5]   = 16'h3123;
      rom[9]   = 16'h9999;
      rom[127] = 16'h7F7F;

      test_reset();
      test_ld_pend();
      test_pending_up();
      test_ir_up_valid();
      test_wrap();
      test_clr_wait();
      test_reset_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
